draw_layer_sequencer: RTL and testbench
=======================================

# draw_layer_sequencer

Parametrised VGA draw arbiter that sequences N independent drawing sources (map background, link, enemies) into the single VGA write port once per frame. It replaces the fixed two-way map/link mux in the game datapath, and sits between the control FSM and the VGA adapter. It grants one layer at a time in ascending index order, so layer 0 is the background. It registers the granted layer's pixel stream onto the VGA port and guards every layer with a watchdog.

## Interface
- NUM_LAYERS, 4, number of drawing sources (≥1); index 0 drawn first
- X_WIDTH, 9, pixel x coordinate width
- Y_WIDTH, 8, pixel y coordinate width
- COLOUR_WIDTH, 3, pixel colour width
- TIMEOUT_CYCLES, 65536, max cycles a layer may hold the grant; 0 disables watchdog
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse from control: begin a frame
- layer_enable  in  NUM_LAYERS  layers to draw this frame; sampled only on accepted frame_start
- layer_x  in  NUM_LAYERS*X_WIDTH  packed x per layer; layer i at [i*X_WIDTH +: X_WIDTH]
- layer_y  in  NUM_LAYERS*Y_WIDTH  packed y per layer
- layer_colour  in  NUM_LAYERS*COLOUR_WIDTH  packed colour per layer
- layer_write  in  NUM_LAYERS  per-layer pixel write strobe
- layer_done  in  NUM_LAYERS  per-layer draw finished (level or pulse)
- layer_go  out  NUM_LAYERS  one-hot draw enable to the granted layer
- x_position  out  X_WIDTH  VGA x
- y_position  out  Y_WIDTH  VGA y
- colour  out  COLOUR_WIDTH  VGA colour
- VGA_enable  out  1  VGA write enable
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the last enabled layer finishes
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy
- layer_timeout  out  NUM_LAYERS  sticky per-layer watchdog flags

## Operation
- States: IDLE, SELECT, DRAW, FINISH.
- IDLE: busy=0. On frame_start, latch layer_enable into pending mask, clear layer_timeout, go to SELECT.
- SELECT: pick the lowest set bit of pending as cur and clear it, then go to DRAW. If pending is empty, go to FINISH.
- DRAW: layer_go[cur]=1, all other go bits 0. Watchdog counter runs from 0.
  - Exit when layer_done[cur]=1, or when the counter reaches TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0. On timeout, set layer_timeout[cur].
  - Either exit goes to SELECT.
- FINISH: frame_done=1 for one cycle, then go to IDLE.
- Pixel path registered each cycle:
  - In DRAW: x_position/y_position/colour ← cur slice of layer_x/layer_y/layer_colour, and VGA_enable ← layer_write[cur].
  - In all other states: VGA_enable ← 0 and coordinates hold.
- layer_done and layer_write from non-granted layers are ignored.
- frame_start while busy is dropped, frame_overrun pulses, and the current frame is unaffected.
- Watchdog counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, counter 0. Reset mid-frame aborts immediately and layer_go drops asynchronously.
- The frame_start edge is cycle 0.
  - Cycle 1: SELECT, busy=1.
  - Cycle 2: layer_go of the first enabled layer goes high.
- Pixel latency: a layer's write at cycle t appears on VGA_enable/x/y/colour at t+1.
- layer_done[cur] sampled at cycle t:
  - layer_go drops at t+1 (SELECT).
  - The next layer's go rises at t+2.
  - A write coincident with done at cycle t is still forwarded at t+1.
- After the last layer's done at t: SELECT at t+1, FINISH (frame_done=1) at t+2, IDLE (busy=0) at t+3.
- All layers disabled: frame_done at cycle 2, busy low at cycle 3.
- A frame_start on the same cycle as the frame_done pulse is an overrun. A frame_start on the next cycle (IDLE) is accepted.
- Per-layer overhead: 2 cycles (SELECT + done-detect), plus 2 cycles per frame.

## Test plan
- Reset then frame_start with layer_enable=4'b1111:
  - Each layer asserts done 10 cycles after its go.
  - layer_go is seen as 0001, 0010, 0100, 1000 in order; never two bits high.
  - frame_done pulses exactly once; busy is high for 50 cycles.
- Layer 1 drives x=9'd319, y=8'd239, colour=3'b101, write=1 at cycle t → the VGA port shows those exact values with VGA_enable=1 at t+1. Layer 2 writes while not granted → VGA_enable stays 0.
- layer_enable=4'b1010 → only go bits 0010 then 1000 appear. layer_enable=0 → frame_done at cycle 2 with no go asserted.
- TIMEOUT_CYCLES=8 and layer 2 never asserts done:
  - layer_go[2] stays high for exactly 8 cycles.
  - layer_timeout=4'b0100 afterwards, and layer 3 still runs.
  - The next frame_start clears the flag.
- frame_start pulsed while busy → frame_overrun pulses for 1 cycle; layer order and frame_done count are unchanged.
- reset asserted mid-DRAW of layer 1 → all outputs 0 immediately. After release, a new frame_start restarts from layer 0.

Source files
------------

// File: rtl/draw_layer_sequencer.sv
// draw_layer_sequencer: grants N draw layers one at a time, in ascending index order, onto one registered VGA write port
// Ports: frame_start/layer_enable start a frame. layer_x/y/colour/write/done are the per-layer packed source streams.
// layer_go is the one-hot grant. x_position/y_position/colour/VGA_enable are the registered VGA port.
// busy, frame_done and frame_overrun give frame status. layer_timeout holds the sticky per-layer watchdog flags.
module draw_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int X_WIDTH        = 9,
  parameter int Y_WIDTH        = 8,
  parameter int COLOUR_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               frame_start,
  input  logic [NUM_LAYERS-1:0]              layer_enable,
  input  logic [NUM_LAYERS*X_WIDTH-1:0]      layer_x,
  input  logic [NUM_LAYERS*Y_WIDTH-1:0]      layer_y,
  input  logic [NUM_LAYERS*COLOUR_WIDTH-1:0] layer_colour,
  input  logic [NUM_LAYERS-1:0]              layer_write,
  input  logic [NUM_LAYERS-1:0]              layer_done,
  output logic [NUM_LAYERS-1:0]              layer_go,
  output logic [X_WIDTH-1:0]                 x_position,
  output logic [Y_WIDTH-1:0]                 y_position,
  output logic [COLOUR_WIDTH-1:0]            colour,
  output logic                               VGA_enable,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               frame_overrun,
  output logic [NUM_LAYERS-1:0]              layer_timeout
);
  localparam int CUR_W = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, SELECT, DRAW, FINISH} state_t;
  state_t state_q, state_d;
  logic [NUM_LAYERS-1:0] pending_q, pending_d, timeout_q, timeout_d;
  logic [CUR_W-1:0] cur_q, cur_d, lowest;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
  logic vga_en_q, vga_en_d;
  logic cur_done, wd_hit;
  // lowest-index pending layer wins; the loop runs downward so the last hit is the lowest
  always_comb begin
    lowest = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (pending_q[i]) lowest = CUR_W'(i);
  end
  always_comb begin
    cur_done = layer_done[cur_q];
    wd_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = frame_start ? SELECT : IDLE;
      SELECT:  state_d = |pending_q ? DRAW : FINISH;
      DRAW:    state_d = (cur_done || wd_hit) ? SELECT : DRAW;
      default: state_d = IDLE;
    endcase
  end
  // pending loses its lowest set bit as that layer is selected
  always_comb begin
    pending_d = pending_q;
    timeout_d = timeout_q;
    cur_d = cur_q;
    cnt_d = '0;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    vga_en_d = 1'b0;
    if (state_q == IDLE && frame_start) begin
      pending_d = layer_enable;
      timeout_d = '0;
    end
    if (state_q == SELECT) begin
      cur_d = lowest;
      pending_d = pending_q & (pending_q - NUM_LAYERS'(1));
    end
    if (state_q == DRAW) begin
      cnt_d = cnt_q == CNT_MAX ? cnt_q : cnt_q + CNT_W'(1);
      x_d = layer_x[cur_q*X_WIDTH +: X_WIDTH];
      y_d = layer_y[cur_q*Y_WIDTH +: Y_WIDTH];
      colour_d = layer_colour[cur_q*COLOUR_WIDTH +: COLOUR_WIDTH];
      vga_en_d = layer_write[cur_q];
      // a done arriving on the watchdog's last cycle counts as a normal finish
      if (wd_hit && !cur_done) timeout_d[cur_q] = 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pending_q <= '0;
      timeout_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      vga_en_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      timeout_q <= timeout_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      vga_en_q <= vga_en_d;
    end
  // grant is decoded straight from state so an async reset drops it at once
  always_comb begin
    layer_go = '0;
    if (state_q == DRAW) layer_go[cur_q] = 1'b1;
    busy = state_q != IDLE;
    frame_done = state_q == FINISH;
    frame_overrun = frame_start && state_q != IDLE;
    x_position = x_q;
    y_position = y_q;
    colour = colour_q;
    VGA_enable = vga_en_q;
    layer_timeout = timeout_q;
  end
endmodule

// File: tb/tb_draw_layer_sequencer.sv
// tb_draw_layer_sequencer: randomized scoreboard bench for draw_layer_sequencer
module tb_draw_layer_sequencer;
  localparam int NL = 4, XW = 9, YW = 8, CW = 3, TO = 12;
  logic clock = 1'b0, reset = 1'b1, frame_start = 1'b0;
  logic [NL-1:0] layer_enable = '0, layer_write = '0, layer_done = '0;
  logic [NL*XW-1:0] layer_x = '0;
  logic [NL*YW-1:0] layer_y = '0;
  logic [NL*CW-1:0] layer_colour = '0;
  logic [NL-1:0] layer_go, layer_timeout;
  logic [XW-1:0] x_position;
  logic [YW-1:0] y_position;
  logic [CW-1:0] colour;
  logic VGA_enable, busy, frame_done, frame_overrun;
  draw_layer_sequencer #(.NUM_LAYERS(NL), .X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .layer_enable(layer_enable),
    .layer_x(layer_x), .layer_y(layer_y), .layer_colour(layer_colour), .layer_write(layer_write),
    .layer_done(layer_done), .layer_go(layer_go), .x_position(x_position), .y_position(y_position),
    .colour(colour), .VGA_enable(VGA_enable), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .layer_timeout(layer_timeout));
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  typedef struct {int idx; int start; int len;} grant_t;
  typedef struct {int x; int y; int c; int t;} pix_t;
  typedef struct {int c0; int done; logic [NL-1:0] tmask;} frame_t;
  grant_t grant_q[$];
  pix_t pix_q[$];
  frame_t frame_q[$];
  int ov_q[$];
  int checks = 0, errors = 0, last_done = 0;
  int plan_d[NL];
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic to_cycle(input int t);
    while (cyc < t) step();
  endtask
  task automatic check_zero();
    chk("rst_go", int'(layer_go), 0);
    chk("rst_x", int'(x_position), 0);
    chk("rst_y", int'(y_position), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_vga_en", int'(VGA_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(frame_overrun), 0);
    chk("rst_timeout", int'(layer_timeout), 0);
  endtask
  task automatic set_plan(input bit hang_ok);
    for (int i = 0; i < NL; i++)
      plan_d[i] = (hang_ok && $urandom_range(5) == 0) ? -1 : int'($urandom_range(10));
  endtask
  // reference: enabled layers in ascending order; each costs its draw length plus one select cycle
  task automatic model(input logic [NL-1:0] mask, output int done);
    grant_t g;
    frame_t f;
    int t;
    f.c0 = cyc;
    f.tmask = '0;
    t = cyc + 2;
    for (int i = 0; i < NL; i++)
      if (mask[i]) begin
        g.idx = i;
        g.start = t;
        g.len = plan_d[i] < 0 ? TO : plan_d[i] + 1;
        if (plan_d[i] < 0) f.tmask[i] = 1'b1;
        grant_q.push_back(g);
        t += g.len + 1;
      end
    f.done = t;
    frame_q.push_back(f);
    done = t;
  endtask
  task automatic frame(input logic [NL-1:0] mask, input bit ov_mid, input bit ov_done);
    int d, o, c0;
    c0 = cyc;
    frame_start = 1'b1;
    layer_enable = mask;
    model(mask, d);
    step();
    frame_start = 1'b0;
    layer_enable = NL'($urandom);
    if (ov_mid) begin
      o = $urandom_range(d - 1, c0 + 1);
      to_cycle(o);
      frame_start = 1'b1;
      layer_enable = NL'($urandom);
      ov_q.push_back(o);
      step();
      frame_start = 1'b0;
    end
    to_cycle(d);
    if (ov_done) begin
      frame_start = 1'b1;
      ov_q.push_back(d);
    end
    last_done = d;
  endtask
  // layer sources: granted layers finish after their planned delay, others emit ignored garbage
  initial begin : driver
    int age[NL];
    bit active[NL];
    pix_t p;
    int x, y, c, w;
    for (int i = 0; i < NL; i++) begin
      age[i] = 0;
      active[i] = 1'b0;
    end
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NL; i++) begin
        if (layer_go[i]) begin
          age[i] = active[i] ? age[i] + 1 : 0;
          active[i] = 1'b1;
        end else active[i] = 1'b0;
        if ($urandom_range(3) == 0) begin
          x = 319; y = 239; c = 5;
        end else begin
          x = $urandom_range(511); y = $urandom_range(255); c = $urandom_range(7);
        end
        w = $urandom_range(1);
        layer_x[i*XW +: XW] = XW'(x);
        layer_y[i*YW +: YW] = YW'(y);
        layer_colour[i*CW +: CW] = CW'(c);
        layer_write[i] = w != 0;
        layer_done[i] = layer_go[i] ? (plan_d[i] >= 0 && age[i] == plan_d[i]) : ($urandom_range(3) == 0);
        if (layer_go[i] && w != 0) begin
          p.x = x; p.y = y; p.c = c; p.t = cyc + 1;
          pix_q.push_back(p);
        end
      end
    end
  end
  initial begin : monitor
    logic [NL-1:0] prev_go;
    int g_start, g_len, busy_cnt, o;
    grant_t g;
    pix_t p;
    frame_t f;
    prev_go = '0; g_start = 0; g_len = 0; busy_cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_go = '0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (layer_go != prev_go) begin
          if (prev_go != '0) chk("go_len", cyc - g_start, g_len);
          if (layer_go != '0) begin
            if (grant_q.size() == 0) chk("go_unexpected", int'(layer_go), 0);
            else begin
              g = grant_q.pop_front();
              chk("go_layer", int'(layer_go), 1 << g.idx);
              chk("go_start", cyc, g.start);
              g_start = cyc;
              g_len = g.len;
            end
          end
          prev_go = layer_go;
        end
        if (VGA_enable) begin
          if (pix_q.size() == 0) chk("pix_unexpected", int'(VGA_enable), 0);
          else begin
            p = pix_q.pop_front();
            chk("pix_x", int'(x_position), p.x);
            chk("pix_y", int'(y_position), p.y);
            chk("pix_colour", int'(colour), p.c);
            chk("pix_cycle", cyc, p.t);
          end
        end
        if (frame_done) begin
          if (frame_q.size() == 0) chk("done_unexpected", int'(frame_done), 0);
          else begin
            f = frame_q.pop_front();
            chk("done_cycle", cyc, f.done);
            chk("timeout_flags", int'(layer_timeout), int'(f.tmask));
            chk("busy_cycles", busy_cnt, f.done - f.c0);
          end
          busy_cnt = 0;
        end
        if (frame_overrun) begin
          if (ov_q.size() == 0) chk("overrun_unexpected", int'(frame_overrun), 0);
          else begin
            o = ov_q.pop_front();
            chk("overrun_cycle", cyc, o);
          end
        end
      end
    end
  end
  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin : main
    int d, c0;
    bit ovd;
    for (int i = 0; i < NL; i++) plan_d[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    check_zero();
    reset = 1'b0;
    step();
    for (int i = 0; i < NL; i++) plan_d[i] = 10;
    frame('1, 1'b0, 1'b0);
    step();
    step();
    set_plan(1'b0);
    frame(NL'(4'b1010), 1'b0, 1'b0);
    step();
    frame('0, 1'b0, 1'b0);
    step();
    plan_d[0] = 3; plan_d[1] = 4; plan_d[2] = -1; plan_d[3] = 5;
    frame('1, 1'b0, 1'b0);
    step();
    set_plan(1'b0);
    frame('1, 1'b1, 1'b1);
    step();
    set_plan(1'b0);
    frame(NL'($urandom), 1'b0, 1'b0);
    step();
    for (int i = 0; i < NL; i++) plan_d[i] = 10;
    c0 = cyc;
    frame_start = 1'b1;
    layer_enable = '1;
    model('1, d);
    step();
    frame_start = 1'b0;
    to_cycle(c0 + 17);
    #2;
    reset = 1'b1;
    #1;
    check_zero();
    grant_q.delete();
    pix_q.delete();
    frame_q.delete();
    ov_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    set_plan(1'b1);
    frame('1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 40; k++) begin
      set_plan(1'b1);
      ovd = $urandom_range(3) == 0;
      frame(NL'($urandom), $urandom_range(3) == 0, ovd);
      step();
      if (!ovd) begin
        frame_start = 1'b0;
        repeat ($urandom_range(2)) step();
      end
    end
    frame_start = 1'b0;
    to_cycle(last_done + 4);
    chk("end_grant_q", grant_q.size(), 0);
    chk("end_pix_q", pix_q.size(), 0);
    chk("end_frame_q", frame_q.size(), 0);
    chk("end_ov_q", ov_q.size(), 0);
    chk("end_busy", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
